// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, line levels, default sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

  // 2-of-3 vote used to reject single-tick glitches on the line.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: byte, valid/error strobes and busy status.
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::UART_DATA_BITS_DEF
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; RST_VAL sets the reset level of both flops.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1-style oversampling UART receiver; one-cycle rx_valid / frame_err pulses after the stop sample.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit sample, decision one tick later.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int DATA_BITS  = UART_DATA_BITS_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      os_tick,
  input  logic      rx,
  uart_rx_if.master rx_if
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [OW-1:0] CNT_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [OW-1:0] CNT_START = OW'(OVERSAMPLE / 2);
`else
  localparam logic [OW-1:0] CNT_START = OW'(OVERSAMPLE / 2 - 1);
`endif

  logic rx_s;
  logic sample;

  uart_rx_state_t       state_q, state_d;
  logic [OW-1:0]        os_cnt_q, os_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Last two tick samples; combined with the current one at mid+1 they span mid-1..mid+1.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (os_tick) begin
      hist_d = {hist_q[0], rx_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_tick ? os_cnt_q + 1'b1 : os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        os_cnt_d  = '0;
        bit_cnt_d = '0;
        if (rx_s == UART_START_BIT) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (os_tick && os_cnt_q == CNT_START) begin
          state_d   = (sample == UART_START_BIT) ? ST_DATA : ST_IDLE;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      end

      // Data sampling runs a full bit period after the start check, so the counter just wraps.
      ST_DATA: begin
        if (os_tick && os_cnt_q == CNT_LAST) begin
          shift_d   = {sample, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = ST_STOP;
            os_cnt_d  = '0;
            bit_cnt_d = '0;
          end
        end
      end

      ST_STOP: begin
        if (os_tick && os_cnt_q == CNT_LAST) begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          if (sample == UART_STOP_BIT) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end

      // A held-low line (break) reports once, then waits here for the line to recover.
      ST_WAIT_IDLE: begin
        os_cnt_d  = '0;
        bit_cnt_d = '0;
        if (rx_s == UART_STOP_BIT) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        os_cnt_d  = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: OVERSAMPLE 16, one os_tick every 4 clk cycles, line driven per tick window.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic os_tick = 1'b0;
  logic rx      = 1'b1;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .os_tick (os_tick),
    .rx      (rx),
    .rx_if   (rx_if)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks     = 0;
  int         failures   = 0;
  int         good_seen  = 0;
  int         err_seen   = 0;
  logic [7:0] last_good  = 8'h00;
  logic [7:0] glitch_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // One os_tick period with the line at level v; entered and left on a falling clk edge.
  task automatic tick_window(input logic v);
    rx      = v;
    os_tick = 1'b1;
    @(negedge clk);
    os_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_window(1'b1);
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int w);
    int idx;
    idx = w / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return stop;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_win);
    logic v;
    for (int w = 0; w < 160; w++) begin
      v = frame_bit(d, stop, w);
      if (w == glitch_win) v = ~v;
      tick_window(v);
    end
  endtask

  task automatic expect_good(input logic [7:0] d);
    sb.push_back('{is_err: 1'b0, data: d});
    last_good = d;
  endtask

  task automatic expect_err();
    sb.push_back('{is_err: 1'b1, data: last_good});
  endtask

  // Monitor: every output strobe must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rx_if.rx_valid || rx_if.frame_err)) begin
        check("valid_err_exclusive", {31'd0, rx_if.rx_valid & rx_if.frame_err}, 32'd0);
        if (rx_if.rx_valid) good_seen++;
        if (rx_if.frame_err) err_seen++;
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, rx_if.rx_valid, rx_if.frame_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", {31'd0, rx_if.frame_err}, {31'd0, e.is_err});
          check("rx_data", {24'd0, rx_if.rx_data}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, rx_if.frame_err}, 32'd0);
    check("reset_busy", {31'd0, rx_if.busy}, 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Basic frame
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    idle(8);
    check("basic_busy_idle", {31'd0, rx_if.busy}, 32'd0);
    check("basic_good_cnt", good_seen, 1);

    // Back-to-back frames, no idle gap
    expect_good(8'h00);
    expect_good(8'hFF);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(8);
    check("b2b_good_cnt", good_seen, 3);

    // False start: 4 ticks low
    for (int i = 0; i < 4; i++) tick_window(1'b0);
    idle(24);
    check("false_start_busy", {31'd0, rx_if.busy}, 32'd0);
    check("false_start_good_cnt", good_seen, 3);
    check("false_start_err_cnt", err_seen, 0);
    expect_good(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    idle(8);

    // Framing error followed by a break
    expect_err();
    send_frame(8'h3C, 1'b0, -1);
    for (int i = 0; i < 40; i++) tick_window(1'b0);
    check("break_busy", {31'd0, rx_if.busy}, 32'd1);
    check("break_err_cnt", err_seen, 1);
    check("break_data_held", {24'd0, rx_if.rx_data}, 32'h3C);
    idle(20);
    check("break_recovered", {31'd0, rx_if.busy}, 32'd0);
    expect_good(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    idle(8);

    // Reset in the middle of data bit 4
    for (int w = 0; w < 85; w++) tick_window(frame_bit(8'hFF, 1'b1, w));
    check("pre_reset_busy", {31'd0, rx_if.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check("midrst_frame_err", {31'd0, rx_if.frame_err}, 32'd0);
    check("midrst_busy", {31'd0, rx_if.busy}, 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1, -1);
    idle(8);

    // One-tick glitch on the sampled tick of data bit 3
    expect_good(glitch_exp);
    send_frame(8'h00, 1'b1, 16 * 4 + 7);
    idle(8);

    check("final_queue_empty", sb.size(), 0);
    check("final_good_cnt", good_seen, 7);
    check("final_err_cnt", err_seen, 1);
    check("final_busy", {31'd0, rx_if.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
